// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : 256x8 byte memory that serves processor requests and loader
//               writes. The processor path inserts WAIT_STATES idle cycles
//               before each access. The loader path writes directly from IDLE.
//               When both request in the same cycle, the processor wins.
// Ports       : clock            - single clock, rising-edge active
//               reset            - asynchronous active-low reset
//               MemRead/MemWrite - processor request levels (write wins)
//               address/data     - processor byte address / write data
//               q                - registered read data, held between reads
//               ready            - one-cycle processor completion pulse
//               ld_valid/ld_addr/ld_data - loader write request
//               ld_ready         - one-cycle loader acknowledge
//               busy             - high whenever the FSM is not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int WAIT_STATES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  output logic       ready,
  input  logic       ld_valid,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_LOAD   = 2'd3
  } state_t;

  // Counter start value. When WAIT_STATES is zero the WAIT state is skipped,
  // so the value is never used.
  localparam logic [3:0] c_wait_init = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic       r_is_write;
  logic [7:0] r_q;
  logic [7:0] r_mem [256];

  logic       w_req;
  logic       w_accept;
  logic       w_load;
  logic       w_enter_access;
  logic       w_acc_write;
  logic [7:0] w_acc_addr;
  logic [7:0] w_acc_data;

  assign w_req = MemRead | MemWrite;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_next = ST_ACCESS;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = c_wait_init;
          end
        end else if (ld_valid) begin
          w_load       = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_ACCESS;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_ACCESS: w_state_next = ST_IDLE;
      ST_LOAD:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // With zero wait states, ACCESS is entered on the accepting edge itself,
  // before the latched copies exist. In that case the live inputs are used.
  assign w_enter_access = (w_state_next == ST_ACCESS);
  assign w_acc_write    = (r_state == ST_IDLE) ? MemWrite : r_is_write;
  assign w_acc_addr     = (r_state == ST_IDLE) ? address  : r_addr;
  assign w_acc_data     = (r_state == ST_IDLE) ? data     : r_data;

  // --------------------------------------------------------------------------
  // State, counter, latched request and read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 8'h00;
      r_data     <= 8'h00;
      r_is_write <= 1'b0;
      r_q        <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= address;
        r_data     <= data;
        r_is_write <= MemWrite;
      end
      if (w_enter_access && !w_acc_write) begin
        r_q <= r_mem[w_acc_addr];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage. It has no reset value, but reset still blocks writes. While
  // reset is held, nothing can land in memory, and an abandoned transaction
  // never commits its write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (reset) begin
      if (w_enter_access && w_acc_write) begin
        r_mem[w_acc_addr] <= w_acc_data;
      end else if (w_load) begin
        r_mem[ld_addr] <= ld_data;
      end
    end
  end

  assign q        = r_q;
  assign ready    = (r_state == ST_ACCESS);
  assign ld_ready = (r_state == ST_LOAD);
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder. It runs three
//               instances with WAIT_STATES = 1, 0 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mem_read  [3];
  logic       mem_write [3];
  logic [7:0] addr      [3];
  logic [7:0] wdata     [3];
  logic [7:0] q         [3];
  logic       ready     [3];
  logic       ld_valid  [3];
  logic [7:0] ld_addr   [3];
  logic [7:0] ld_data   [3];
  logic       ld_ready  [3];
  logic       busy      [3];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=0, instance 2: WAIT_STATES=3
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_responder #(.WAIT_STATES(gi == 0 ? 1 : (gi == 1 ? 0 : 3))) u_dut (
      .clock    (clock),
      .reset    (reset_n),
      .MemRead  (mem_read[gi]),
      .MemWrite (mem_write[gi]),
      .address  (addr[gi]),
      .data     (wdata[gi]),
      .q        (q[gi]),
      .ready    (ready[gi]),
      .ld_valid (ld_valid[gi]),
      .ld_addr  (ld_addr[gi]),
      .ld_data  (ld_data[gi]),
      .ld_ready (ld_ready[gi]),
      .busy     (busy[gi])
    );
  end

  // Processor transaction. lat is the count of negedge samples after the
  // request is raised until ready is seen, so the accept cycle counts as 1.
  // A timeout returns lat = -1.
  task automatic do_op(input int k, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] qv);
    lat = -1;
    qv  = 8'h00;
    @(negedge clock);
    mem_read[k] = rd; mem_write[k] = wr; addr[k] = a; wdata[k] = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (ready[k] === 1'b1) begin
        lat = n;
        qv  = q[k];
        break;
      end
    end
    mem_read[k] = 1'b0; mem_write[k] = 1'b0;
  endtask

  task automatic ld_op(input int k, input logic [7:0] a, input logic [7:0] d, output int lat);
    lat = -1;
    @(negedge clock);
    ld_valid[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (ld_ready[k] === 1'b1) begin
        lat = n;
        break;
      end
    end
    ld_valid[k] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      checks++; if (q[k] !== 8'h00) begin errors++; $display("FAIL reset_q[%0d]: got %h expected 00", k, q[k]); end
      checks++; if (ready[k] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, ready[k]); end
      checks++; if (ld_ready[k] !== 1'b0) begin errors++; $display("FAIL reset_ld_ready[%0d]: got %b expected 0", k, ld_ready[k]); end
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", k, busy[k]); end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_ws1_write_read();
    int lat; logic [7:0] qv;
    do_op(0, 1'b0, 1'b1, 8'h10, 8'h5A, lat, qv);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ws1_write_lat: got %0d expected 2", lat); end
    checks++; if (qv !== 8'h00) begin errors++; $display("FAIL ws1_write_q_hold: got %h expected 00", qv); end
    do_op(0, 1'b1, 1'b0, 8'h10, 8'h00, lat, qv);
    checks++; if (lat !== 2) begin errors++; $display("FAIL ws1_read_lat: got %0d expected 2", lat); end
    checks++; if (qv !== 8'h5A) begin errors++; $display("FAIL ws1_read_q: got %h expected 5a", qv); end
  endtask

  task automatic test_ws0_loader_read();
    int lat; logic [7:0] qv;
    ld_op(1, 8'hFF, 8'hC3, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_ld_lat: got %0d expected 1", lat); end
    do_op(1, 1'b1, 1'b0, 8'hFF, 8'h00, lat, qv);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_read_lat: got %0d expected 1", lat); end
    checks++; if (qv !== 8'hC3) begin errors++; $display("FAIL ws0_read_q: got %h expected c3", qv); end
  endtask

  task automatic test_rw_both();
    int lat; logic [7:0] qv;
    do_op(0, 1'b1, 1'b1, 8'h20, 8'h77, lat, qv);
    checks++; if (lat !== 2) begin errors++; $display("FAIL both_lat: got %0d expected 2", lat); end
    checks++; if (qv !== 8'h5A) begin errors++; $display("FAIL both_q_unchanged: got %h expected 5a", qv); end
    do_op(0, 1'b1, 1'b0, 8'h20, 8'h00, lat, qv);
    checks++; if (qv !== 8'h77) begin errors++; $display("FAIL both_readback: got %h expected 77", qv); end
  endtask

  task automatic test_arbitration();
    int rcyc = -1, lcyc = -1, rcnt = 0, lcnt = 0, lat;
    logic [7:0] qv = 8'h00;
    logic [7:0] qr;
    @(negedge clock);
    mem_read[0] = 1'b1; addr[0] = 8'h10;
    ld_valid[0] = 1'b1; ld_addr[0] = 8'h30; ld_data[0] = 8'hE1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (ready[0] === 1'b1) begin rcnt++; rcyc = n; qv = q[0]; mem_read[0] = 1'b0; end
      if (ld_ready[0] === 1'b1) begin lcnt++; lcyc = n; ld_valid[0] = 1'b0; end
    end
    mem_read[0] = 1'b0; ld_valid[0] = 1'b0;
    checks++; if (rcyc !== 2) begin errors++; $display("FAIL arb_ready_cycle: got %0d expected 2", rcyc); end
    checks++; if (lcyc !== 4) begin errors++; $display("FAIL arb_ld_ready_cycle: got %0d expected 4", lcyc); end
    checks++; if (rcnt !== 1) begin errors++; $display("FAIL arb_ready_count: got %0d expected 1", rcnt); end
    checks++; if (lcnt !== 1) begin errors++; $display("FAIL arb_ld_ready_count: got %0d expected 1", lcnt); end
    checks++; if (qv !== 8'h5A) begin errors++; $display("FAIL arb_read_q: got %h expected 5a", qv); end
    do_op(0, 1'b1, 1'b0, 8'h30, 8'h00, lat, qr);
    checks++; if (qr !== 8'hE1) begin errors++; $display("FAIL arb_loaded_byte: got %h expected e1", qr); end
  endtask

  task automatic test_back_to_back();
    int r1 = -1, r2 = -1, nready = 0, busy_low = 0;
    logic [7:0] q1 = 8'h00, q2 = 8'h00;
    logic       b3 = 1'b1;
    @(negedge clock);
    mem_read[0] = 1'b1; addr[0] = 8'h20;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      if (n <= 5 && busy[0] === 1'b0) busy_low++;
      if (n == 3) b3 = busy[0];
      if (ready[0] === 1'b1) begin
        nready++;
        if (nready == 1) begin r1 = n; q1 = q[0]; end
        if (nready == 2) begin r2 = n; q2 = q[0]; mem_read[0] = 1'b0; end
      end
    end
    mem_read[0] = 1'b0;
    checks++; if (r1 !== 2) begin errors++; $display("FAIL b2b_first_ready: got %0d expected 2", r1); end
    checks++; if (r2 !== 5) begin errors++; $display("FAIL b2b_second_ready: got %0d expected 5", r2); end
    checks++; if (nready !== 2) begin errors++; $display("FAIL b2b_ready_count: got %0d expected 2", nready); end
    checks++; if (busy_low !== 1) begin errors++; $display("FAIL b2b_busy_low_cycles: got %0d expected 1", busy_low); end
    checks++; if (b3 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap_busy: got %b expected 0", b3); end
    checks++; if (q1 !== 8'h77 || q2 !== 8'h77) begin errors++; $display("FAIL b2b_q: got %h/%h expected 77/77", q1, q2); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] qv;
    do_op(2, 1'b0, 1'b1, 8'h40, 8'h21, lat, qv);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_write_lat: got %0d expected 4", lat); end
    do_op(2, 1'b1, 1'b0, 8'h40, 8'h00, lat, qv);
    checks++; if (qv !== 8'h21) begin errors++; $display("FAIL ws3_read_q: got %h expected 21", qv); end
    @(negedge clock);
    mem_write[2] = 1'b1; addr[2] = 8'h40; wdata[2] = 8'h99;
    @(negedge clock);
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL abort_busy_in_wait: got %b expected 1", busy[2]); end
    reset_n = 1'b0;
    mem_write[2] = 1'b0;
    #1;
    checks++; if (q[2] !== 8'h00) begin errors++; $display("FAIL abort_q_zero: got %h expected 00", q[2]); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL abort_busy_zero: got %b expected 0", busy[2]); end
    checks++; if (ready[2] !== 1'b0) begin errors++; $display("FAIL abort_ready_zero: got %b expected 0", ready[2]); end
    @(negedge clock);
    reset_n = 1'b1;
    do_op(2, 1'b1, 1'b0, 8'h40, 8'h00, lat, qv);
    checks++; if (lat !== 4) begin errors++; $display("FAIL abort_read_lat: got %0d expected 4", lat); end
    checks++; if (qv !== 8'h21) begin errors++; $display("FAIL abort_old_value: got %h expected 21", qv); end
    do_op(0, 1'b1, 1'b0, 8'h10, 8'h00, lat, qv);
    checks++; if (qv !== 8'h5A) begin errors++; $display("FAIL storage_survives_reset: got %h expected 5a", qv); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mem_read[k] = 1'b0; mem_write[k] = 1'b0; addr[k] = 8'h00; wdata[k] = 8'h00;
      ld_valid[k] = 1'b0; ld_addr[k] = 8'h00; ld_data[k] = 8'h00;
    end
    test_reset();
    test_ws1_write_read();
    test_ws0_loader_read();
    test_rw_both();
    test_arbitration();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, giving the number of idle cycles inserted before each processor access; legal range is 0..15.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port MemRead, input, 1, processor read request (level).
REQ-005 SHALL have port MemWrite, input, 1, processor write request (level).
REQ-006 SHALL have port address, input, 8, processor byte address.
REQ-007 SHALL have port data, input, 8, processor write data.
REQ-008 SHALL have port q, output, 8, registered read data.
REQ-009 SHALL have port ready, output, 1, one-cycle completion pulse for a processor transaction.
REQ-010 SHALL have port ld_valid, input, 1, loader write request (level).
REQ-011 SHALL have port ld_addr, input, 8, loader byte address.
REQ-012 SHALL have port ld_data, input, 8, loader write data.
REQ-013 SHALL have port ld_ready, output, 1, one-cycle loader write acknowledge.
REQ-014 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL contain a 256x8 storage array, indexed directly by the 8-bit address; no wrap or range logic is needed.
REQ-016 SHALL implement FSM states IDLE, WAIT, ACCESS, LOAD.
REQ-017 In IDLE, on a rising edge with MemWrite or MemRead high, SHALL latch address, data and op, then go to WAIT with counter = WAIT_STATES-1; if WAIT_STATES = 0, it SHALL go directly to ACCESS.
REQ-018 If MemWrite and MemRead are both high at acceptance, SHALL treat the request as a write.
REQ-019 In WAIT, SHALL decrement the 4-bit counter each edge and go to ACCESS on the edge where the counter is 0.
REQ-020 On entry to ACCESS, a write SHALL update storage[latched address] and a read SHALL load q with storage[latched address]; ready SHALL be high for exactly the ACCESS cycle.
REQ-021 ACCESS SHALL always return to IDLE on the next edge.
REQ-022 ready SHALL rise exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-023 A request still high in IDLE after ACCESS SHALL be accepted as a new transaction; the initiator deasserts its request during the ready cycle.
REQ-024 q SHALL hold its value until the next read completes; writes SHALL leave q unchanged.
REQ-025 Processor request inputs and ld_valid SHALL be ignored outside IDLE; inputs are not latched again mid-transaction.
REQ-026 In IDLE, with ld_valid high and no processor request, SHALL write ld_data to storage[ld_addr] on the edge, enter LOAD, pulse ld_ready for the LOAD cycle, and then return to IDLE.
REQ-027 If ld_valid and a processor request are present simultaneously in IDLE, the processor SHALL win; the loader waits while holding ld_valid.
REQ-028 A read of an address in the same transaction order after a write SHALL return the newly written byte (no stale-read hazard).

Reset
REQ-029 reset low SHALL immediately force: state = IDLE, counter = 0, q = 0x00, ready = 0, ld_ready = 0, busy = 0.
REQ-030 A transaction in WAIT or ACCESS when reset asserts SHALL be abandoned, and a pending write SHALL NOT reach storage.
REQ-031 Storage contents SHALL NOT be cleared by reset.
REQ-032 After reset deasserts, the first rising edge SHALL evaluate requests from IDLE.

Verification
REQ-033 Scenario (WAIT_STATES=1): write 0x5A to 0x10, then read 0x10 -> each ready 2 cycles after acceptance; q=0x5A on the read's ready cycle.
REQ-034 Scenario (WAIT_STATES=0): read 0xFF after loader wrote 0xC3 there -> ready 1 cycle after acceptance, q=0xC3.
REQ-035 Scenario: MemRead=MemWrite=1, address 0x20, data 0x77 -> treated as write; a later read of 0x20 returns 0x77 and q is unchanged by the write.
REQ-036 Scenario: ld_valid and MemRead rise on the same edge -> processor completes first (ready); ld_ready pulses on the first IDLE edge afterwards; both operations are performed exactly once.
REQ-037 Scenario (WAIT_STATES=3): reset pulsed low during WAIT of a write of 0x99 to 0x40 -> outputs are zero immediately; a read of 0x40 returns the prior value, not 0x99.
REQ-038 Scenario: MemRead held high across ready -> two back-to-back reads, with ready pulses (WAIT_STATES+2) cycles apart; busy is low only in the IDLE cycle between them.
